sequencer_avl_cmd_buffer: RTL and testbench

- Avalon-MM posted-write buffer between the sequencer's Nios data master and the PHY manager slave.
- Absorbs bursts of PHY-manager writes (register file updates, VFIFO increments, FIFO resets) into a small FIFO so the Nios is not stalled through the slave's multi-cycle EXEC handshake.
- Reads are serialised behind all queued writes, preserving program order.
- Single clock domain (avl_clk); downstream master port connects directly to the PHY manager's Avalon slave.

---
 rtl/sequencer_avl_cmd_buffer_if.sv | 23 ++
 rtl/sequencer_avl_cmd_buffer.sv | 163 ++++++++++++++++
 tb/tb_sequencer_avl_cmd_buffer.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sequencer_avl_cmd_buffer_if.sv
// Avalon-MM bus bundle for the sequencer command buffer: master drives the
// request, slave returns readdata/waitrequest.
interface sequencer_avl_cmd_buffer_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) ();
    logic [ADDR_W-1:0] address;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              read;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        output address, write, writedata, read,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, write, writedata, read,
        output readdata, waitrequest
    );
endinterface

// File: rtl/sequencer_avl_cmd_buffer.sv
// Posted-write buffer between the Nios data master and the PHY manager slave.
// Optional downstream waitrequest timeout enabled by SEQ_CMD_BUF_TIMEOUT_EN.
module sequencer_avl_cmd_buffer #(
    parameter int unsigned AVL_DATA_WIDTH  = 32,
    parameter int unsigned AVL_ADDR_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                         avl_clk,
    input  logic                         avl_reset_n,
    sequencer_avl_cmd_buffer_if.slave    s,
    sequencer_avl_cmd_buffer_if.master   m,
    output logic [FIFO_DEPTH_LOG2:0]     fifo_level,
    output logic                         idle,
    output logic                         timeout_err
);

    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned PTR_W = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned IDX_W = FIFO_DEPTH_LOG2;

    typedef struct packed {
        logic [AVL_ADDR_WIDTH-1:0] address;
        logic [AVL_DATA_WIDTH-1:0] writedata;
    } cmd_t;

    typedef enum logic [1:0] {M_IDLE, M_WRITE, M_READ, M_RDONE} state_t;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be non-zero");
    end

    state_t                    state;
    cmd_t                      fifo_mem [DEPTH];
    cmd_t                      head;
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [AVL_DATA_WIDTH-1:0] rd_q;
    logic                      full;
    logic                      empty;
    logic                      rd_busy;
    logic                      push;
    logic                      pop;
    logic                      tmo_hit;
    logic                      xfer_done;

    assign fifo_level = wr_ptr - rd_ptr;
    assign full       = (fifo_level == PTR_W'(DEPTH));
    assign empty      = (fifo_level == '0);
    assign rd_busy    = (state == M_READ) || (state == M_RDONE);
    assign head       = fifo_mem[rd_ptr[IDX_W-1:0]];

    // A write alongside a read is dropped; full comes from registered pointers.
    assign push      = s.write && !s.read && !full && !rd_busy;
    assign xfer_done = !m.waitrequest || tmo_hit;
    assign pop       = (state == M_WRITE) && xfer_done;

    assign s.waitrequest = s.read ? (state != M_RDONE)
                                  : (s.write && (full || rd_busy));
    assign s.readdata    = (state == M_RDONE) ? rd_q : '0;
    assign idle          = empty && (state == M_IDLE);

    // Write FIFO storage (no reset needed, pointers qualify the contents)
    always_ff @(posedge avl_clk) begin
        if (push) begin
            fifo_mem[wr_ptr[IDX_W-1:0]] <= cmd_t'{address: s.address, writedata: s.writedata};
        end
    end

    always_ff @(posedge avl_clk or negedge avl_reset_n) begin
        if (!avl_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Downstream sequencer; every transaction returns through M_IDLE so the
    // strobes are low for at least one cycle between transactions.
    always_ff @(posedge avl_clk or negedge avl_reset_n) begin
        if (!avl_reset_n) begin
            state       <= M_IDLE;
            m.address   <= '0;
            m.writedata <= '0;
            m.write     <= 1'b0;
            m.read      <= 1'b0;
            rd_q        <= '0;
        end else begin
            case (state)
                M_IDLE: begin
                    if (!empty) begin
                        m.address   <= head.address;
                        m.writedata <= head.writedata;
                        m.write     <= 1'b1;
                        state       <= M_WRITE;
                    end else if (push) begin
                        // Bypass so a write into an empty buffer issues next cycle
                        m.address   <= s.address;
                        m.writedata <= s.writedata;
                        m.write     <= 1'b1;
                        state       <= M_WRITE;
                    end else if (s.read) begin
                        m.address <= s.address;
                        m.read    <= 1'b1;
                        state     <= M_READ;
                    end
                end
                M_WRITE: begin
                    if (xfer_done) begin
                        m.write <= 1'b0;
                        state   <= M_IDLE;
                    end
                end
                M_READ: begin
                    if (xfer_done) begin
                        rd_q   <= tmo_hit ? AVL_DATA_WIDTH'(32'hDEAD_BEEF) : m.readdata;
                        m.read <= 1'b0;
                        state  <= M_RDONE;
                    end
                end
                M_RDONE: state <= M_IDLE;
                default: state <= M_IDLE;
            endcase
        end
    end

`ifdef SEQ_CMD_BUF_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit = (m.write || m.read) && m.waitrequest
                     && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Stall counter, cleared in M_IDLE so each transaction starts fresh
    always_ff @(posedge avl_clk or negedge avl_reset_n) begin
        if (!avl_reset_n) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == M_IDLE) begin
                tmo_cnt <= '0;
            end else if ((m.write || m.read) && m.waitrequest) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (tmo_hit) timeout_err <= 1'b1;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always @(posedge avl_clk) begin
        if (avl_reset_n) begin
            assert (!(s.write && s.read))
                else $error("s_write and s_read both high: write dropped");
        end
    end

endmodule

// File: tb/tb_sequencer_avl_cmd_buffer.sv
// Self-checking bench for sequencer_avl_cmd_buffer: directed scenarios plus a
// randomized phase scored against an in-order transaction model.
module tb_sequencer_avl_cmd_buffer;

    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 32;
    localparam int unsigned DL2   = 2;
    localparam int unsigned TMO   = 16;
    localparam int          BOUND = 200;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    logic           avl_clk = 1'b0;
    logic           avl_reset_n = 1'b0;
    logic [DL2:0]   fifo_level;
    logic           idle;
    logic           timeout_err;
    logic           strobe;

    int             total = 0;
    int             bad = 0;
    txn_t           exp_q[$];
    txn_t           obs_q[$];

    int unsigned    wait_fixed = 0;
    bit             wait_rand = 1'b0;
    bit             dn_hold = 1'b0;
    int unsigned    cur_wait = 0;
    int unsigned    busy_cnt = 0;

    logic           prev_hold = 1'b0;
    logic           gap_due = 1'b0;
    logic [1+1+AW+DW-1:0] prev_pl = '0;

    always #5 avl_clk = ~avl_clk;

    sequencer_avl_cmd_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) up ();
    sequencer_avl_cmd_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) dn ();

    sequencer_avl_cmd_buffer #(
        .AVL_DATA_WIDTH (DW),
        .AVL_ADDR_WIDTH (AW),
        .FIFO_DEPTH_LOG2(DL2),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .avl_clk    (avl_clk),
        .avl_reset_n(avl_reset_n),
        .s          (up),
        .m          (dn),
        .fifo_level (fifo_level),
        .idle       (idle),
        .timeout_err(timeout_err)
    );

    function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
        return DW'(a) ^ 32'h0000_2006;
    endfunction

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] want);
        total++;
        assert (got === want)
            else begin
                bad++;
                $error("FAIL %s got=%0h want=%0h", tag, got, want);
            end
    endtask

    task automatic fail_now(input string tag);
        total++;
        bad++;
        $error("FAIL %s got=timeout want=event", tag);
    endtask

    // PHY-manager slave model: waits cur_wait cycles, or forever while dn_hold
    assign strobe         = dn.write | dn.read;
    assign dn.waitrequest = dn_hold | (strobe & (busy_cnt < cur_wait));
    assign dn.readdata    = dn.read ? rd_fn(dn.address) : '0;

    always @(posedge avl_clk) begin
        if (!strobe) begin
            busy_cnt <= 0;
            cur_wait <= wait_rand ? $urandom_range(0, 4) : wait_fixed;
        end else if (dn.waitrequest) begin
            busy_cnt <= busy_cnt + 1;
        end
    end

    // Downstream protocol monitor and transaction logger
    always @(negedge avl_clk) begin
        if (!avl_reset_n) begin
            prev_hold <= 1'b0;
            gap_due   <= 1'b0;
        end else begin
            if (gap_due) check("gap_between_strobes", 96'(strobe), 96'(0));
            if (prev_hold) begin
`ifndef SEQ_CMD_BUF_TIMEOUT_EN
                check("strobe_held_until_release", 96'(strobe), 96'(1));
`endif
                if (strobe) check("payload_stable", 96'({dn.write, dn.read, dn.address, dn.writedata}), 96'(prev_pl));
            end
            if (!(up.read && !up.waitrequest)) check("s_readdata_zero", 96'(up.readdata), 96'(0));
            check("level_bound", 96'(fifo_level <= 4), 96'(1));
            if (strobe && !dn.waitrequest) begin
                obs_q.push_back(txn_t'{dn.write, dn.address, dn.write ? dn.writedata : dn.readdata});
            end
            gap_due   <= strobe && !dn.waitrequest;
            prev_hold <= strobe && dn.waitrequest;
            prev_pl   <= {dn.write, dn.read, dn.address, dn.writedata};
        end
    end

    task automatic up_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int stall);
        up.write = 1'b1;
        up.read = 1'b0;
        up.address = a;
        up.writedata = d;
        stall = 0;
        @(negedge avl_clk);
        while (up.waitrequest !== 1'b0 && stall < BOUND) begin
            stall++;
            @(negedge avl_clk);
        end
        if (stall >= BOUND) fail_now("write_accept");
        @(posedge avl_clk);
        #1;
        up.write = 1'b0;
        exp_q.push_back(txn_t'{1'b1, a, d});
    endtask

    task automatic up_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int stall);
        up.read = 1'b1;
        up.write = 1'b0;
        up.address = a;
        stall = 0;
        @(negedge avl_clk);
        while (up.waitrequest !== 1'b0 && stall < BOUND) begin
            stall++;
            @(negedge avl_clk);
        end
        if (stall >= BOUND) fail_now("read_accept");
        d = up.readdata;
        @(posedge avl_clk);
        #1;
        up.read = 1'b0;
        exp_q.push_back(txn_t'{1'b0, a, rd_fn(a)});
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(idle === 1'b1 && strobe === 1'b0) && n < BOUND) begin
            @(posedge avl_clk);
            #1;
            n++;
        end
        if (n >= BOUND) fail_now("drain_idle");
    endtask

    task automatic compare_log(input string tag);
        txn_t e;
        txn_t o;
        check({tag, "_count"}, 96'(obs_q.size()), 96'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({tag, "_txn"}, 96'(o), 96'(e));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=no_finish want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          st;
        int          stv [6];
        int          seen;
        int          n;
        int          obs_at_5th;
        logic [DW-1:0] rd;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        up.address = '0;
        up.writedata = '0;
        up.write = 1'b0;
        up.read = 1'b0;

        // Reset state
        repeat (3) @(posedge avl_clk);
        #1;
        check("rst_fifo_level", 96'(fifo_level), 96'(0));
        check("rst_idle", 96'(idle), 96'(1));
        check("rst_m_write", 96'(dn.write), 96'(0));
        check("rst_m_read", 96'(dn.read), 96'(0));
        check("rst_s_readdata", 96'(up.readdata), 96'(0));
        check("rst_timeout_err", 96'(timeout_err), 96'(0));
        avl_reset_n = 1'b1;

        // Single write with 3 downstream wait cycles
        wait_fixed = 3;
        @(posedge avl_clk);
        #1;
        up_write(16'h3000, 32'h5, st);
        check("single_accept_stall", 96'(st), 96'(0));
        check("single_m_write_next", 96'(dn.write), 96'(1));
        check("single_level_1", 96'(fifo_level), 96'(1));
        n = 0;
        while (dn.write === 1'b1 && n < 40) begin
            @(posedge avl_clk);
            #1;
            n++;
        end
        check("single_m_write_cycles", 96'(n), 96'(4));
        check("single_level_0", 96'(fifo_level), 96'(0));
        check("single_idle", 96'(idle), 96'(1));
        compare_log("single");

        // Burst of 6 into a depth-4 FIFO, 5 wait cycles each
        wait_fixed = 5;
        @(posedge avl_clk);
        #1;
        obs_at_5th = 0;
        for (int i = 0; i < 6; i++) begin
            up_write(AW'(16'h3100 + i), DW'(32'hA000 + i), st);
            stv[i] = st;
            if (i == 4) obs_at_5th = obs_q.size();
        end
        for (int i = 0; i < 4; i++) check("burst_no_stall", 96'(stv[i]), 96'(0));
        check("burst_5th_stalls", 96'(stv[4] > 0), 96'(1));
        check("burst_5th_after_pop", 96'(obs_at_5th >= 1), 96'(1));
        wait_idle();
        compare_log("burst");

        // Write followed immediately by a read: read ordered behind the write
        wait_fixed = 2;
        @(posedge avl_clk);
        #1;
        up_write(16'h3001, 32'h0000_0077, st);
        up_read(16'h2000, rd, st);
        check("wr_rd_readdata", 96'(rd), 96'(32'h0000_0006));
        wait_idle();
        compare_log("wr_then_rd");

        // Read on empty FIFO, zero downstream wait
        wait_fixed = 0;
        @(posedge avl_clk);
        #1;
        up_read(16'h2345, rd, st);
        check("rd_latency_stall", 96'(st), 96'(2));
        check("rd_data", 96'(rd), 96'(rd_fn(16'h2345)));
        wait_idle();
        compare_log("rd_empty");

        // Asynchronous reset with three writes pending
        wait_fixed = 20;
        @(posedge avl_clk);
        #1;
        for (int i = 0; i < 3; i++) up_write(AW'(16'h3300 + i), DW'(32'hB000 + i), st);
        check("pre_rst_m_write", 96'(dn.write), 96'(1));
        check("pre_rst_level", 96'(fifo_level), 96'(3));
        @(negedge avl_clk);
        #2;
        avl_reset_n = 1'b0;
        #1;
        check("rst_async_m_write", 96'(dn.write), 96'(0));
        check("rst_async_level", 96'(fifo_level), 96'(0));
        check("rst_async_idle", 96'(idle), 96'(1));
        exp_q.delete();
        repeat (2) @(posedge avl_clk);
        #1;
        avl_reset_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge avl_clk);
            if (strobe) seen++;
        end
        check("post_rst_no_issue", 96'(seen), 96'(0));
        check("post_rst_level", 96'(fifo_level), 96'(0));
        compare_log("reset");

        // Downstream held in waitrequest
        dn_hold = 1'b1;
        wait_fixed = 1;
        @(posedge avl_clk);
        #1;
        up_write(16'h3400, 32'h99, st);
        n = 0;
        while (dn.write === 1'b1 && n < 40) begin
            @(posedge avl_clk);
            #1;
            n++;
        end
`ifdef SEQ_CMD_BUF_TIMEOUT_EN
        check("tmo_strobe_cycles", 96'(n), 96'(TMO));
        check("tmo_err_set", 96'(timeout_err), 96'(1));
        check("tmo_level", 96'(fifo_level), 96'(0));
        void'(exp_q.pop_back());
        dn_hold = 1'b0;
        @(posedge avl_clk);
        #1;
        up_write(16'h3401, 32'h9A, st);
        wait_idle();
        check("tmo_err_sticky", 96'(timeout_err), 96'(1));
`else
        check("hold_strobe_cycles", 96'(n), 96'(40));
        check("hold_m_write", 96'(dn.write), 96'(1));
        check("hold_no_tmo_err", 96'(timeout_err), 96'(0));
        dn_hold = 1'b0;
        wait_idle();
        check("hold_tmo_err_low", 96'(timeout_err), 96'(0));
`endif
        compare_log("hold");

        // Randomized mix of writes and reads with random downstream waits
        wait_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a = AW'($urandom_range(0, 16'hFFFF));
            d = $urandom;
            if ($urandom_range(0, 2) < 2) begin
                up_write(a, d, st);
            end else begin
                up_read(a, rd, st);
                check("rand_rd_data", 96'(rd), 96'(rd_fn(a)));
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge avl_clk);
                #1;
            end
        end
        wait_idle();
        compare_log("random");
        check("final_level", 96'(fifo_level), 96'(0));
        check("final_idle", 96'(idle), 96'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
